// File: rtl/vx_lru_way_sched_pkg.sv
// Shared encodings for the per-set LRU way scheduler: request opcodes and FSM states.
package vx_lru_pkg;

    localparam logic [1:0] LRU_OP_TOUCH = 2'd0;
    localparam logic [1:0] LRU_OP_FILL  = 2'd1;
    localparam logic [1:0] LRU_OP_INVAL = 2'd2;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_READY = 2'd1,
        ST_DRAIN = 2'd2
    } lru_state_e;

endpackage

// File: rtl/vx_lru_way_sched_if.sv
// Request/response handshake between the tag-compare stage (master) and the LRU scheduler (slave).
interface vx_lru_way_sched_if #(
    parameter int SET_W = 4,
    parameter int WAY_W = 2
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [SET_W-1:0] req_set;
    logic [WAY_W-1:0] req_way;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [SET_W-1:0] rsp_set;
    logic [WAY_W-1:0] rsp_way;

    modport master (
        output req_valid, req_op, req_set, req_way, rsp_ready,
        input  req_ready, rsp_valid, rsp_set, rsp_way
    );

    modport slave (
        input  req_valid, req_op, req_set, req_way, rsp_ready,
        output req_ready, rsp_valid, rsp_set, rsp_way
    );
endinterface

// File: rtl/vx_lru_order_update.sv
// Combinational recency-order update for one set: TOUCH moves a way to MRU, FILL rotates the LRU
// way to MRU (reporting it as victim), INVAL moves a way to LRU. Position 0 is LRU.
module vx_lru_order_update
    import vx_lru_pkg::*;
#(
    parameter int NUM_WAYS = 4,
    parameter int WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-1:0][WAY_W-1:0] order_in,
    input  logic [1:0]                     op,
    input  logic [WAY_W-1:0]               way,
    output logic [NUM_WAYS-1:0][WAY_W-1:0] order_out,
    output logic [WAY_W-1:0]               victim
);

    logic [WAY_W-1:0] k;

    always_comb begin
        k = '0;
        for (int p = 0; p < NUM_WAYS; p++) begin
            if (order_in[p] == way) begin
                k = WAY_W'(p);
            end
        end
    end

    assign victim = order_in[0];

    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_pos
        localparam logic [WAY_W-1:0] POS = WAY_W'(gi);
        logic [WAY_W-1:0] touch_up;
        logic [WAY_W-1:0] fill_up;
        logic [WAY_W-1:0] dn_val;
        logic [WAY_W-1:0] touch_val;
        logic [WAY_W-1:0] inval_val;

        // Neighbour selection is resolved at elaboration so no index ever leaves the array.
        if (gi == NUM_WAYS - 1) begin : g_top
            assign touch_up = way;
            assign fill_up  = order_in[0];
        end else begin : g_mid
            assign touch_up = order_in[gi+1];
            assign fill_up  = order_in[gi+1];
        end

        if (gi == 0) begin : g_bot
            assign dn_val = way;
        end else begin : g_up
            assign dn_val = order_in[gi-1];
        end

        assign touch_val = (POS < k)  ? order_in[gi] : touch_up;
        assign inval_val = (POS <= k) ? dn_val       : order_in[gi];

        assign order_out[gi] = (op == LRU_OP_TOUCH) ? touch_val :
                               (op == LRU_OP_FILL)  ? fill_up   :
                               (op == LRU_OP_INVAL) ? inval_val :
                                                      order_in[gi];
    end

endmodule

// File: rtl/vx_lru_way_sched.sv
// Per-set LRU replacement scheduler: INIT sweep, one-stage request pipeline with write-back on
// response handshake, and a same-set bypass so back-to-back requests see serial results.
module vx_lru_way_sched
    import vx_lru_pkg::*;
#(
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    output logic                 init_done,
    vx_lru_way_sched_if.slave    bus
);

    localparam int SET_W = $clog2(NUM_SETS);
    localparam int WAY_W = $clog2(NUM_WAYS);

    typedef logic [NUM_WAYS-1:0][WAY_W-1:0] order_t;

    function automatic order_t ident_order();
        order_t o;
        for (int p = 0; p < NUM_WAYS; p++) begin
            o[p] = WAY_W'(p);
        end
        return o;
    endfunction

    function automatic logic is_perm(order_t o);
        logic [NUM_WAYS-1:0] seen;
        seen = '0;
        for (int p = 0; p < NUM_WAYS; p++) begin
            seen[o[p]] = 1'b1;
        end
        return &seen;
    endfunction

    localparam order_t IDENT = ident_order();

    lru_state_e       state_reg, state_next;
    logic [SET_W-1:0] init_ptr_reg, init_ptr_next;
    order_t           order_reg [NUM_SETS];

    logic             s1_valid_reg;
    logic [1:0]       s1_op_reg;
    logic [SET_W-1:0] s1_set_reg;
    logic [WAY_W-1:0] s1_way_reg;
    order_t           s1_order_reg;

    order_t           s1_new_order;
    order_t           s0_order;
    logic [WAY_W-1:0] s1_victim;
    logic             accept;
    logic             rsp_fire;
    logic             init_wr;

    vx_lru_order_update #(
        .NUM_WAYS (NUM_WAYS),
        .WAY_W    (WAY_W)
    ) u_update (
        .order_in  (s1_order_reg),
        .op        (s1_op_reg),
        .way       (s1_way_reg),
        .order_out (s1_new_order),
        .victim    (s1_victim)
    );

    assign bus.req_ready = (state_reg == ST_READY) && !flush && (!s1_valid_reg || bus.rsp_ready);
    assign accept        = bus.req_valid && bus.req_ready;
    assign rsp_fire      = s1_valid_reg && bus.rsp_ready;

    // The set being written back this edge must be read from the update result, not the array.
    assign s0_order = (rsp_fire && (s1_set_reg == bus.req_set)) ? s1_new_order
                                                                 : order_reg[bus.req_set];

    assign bus.rsp_valid = s1_valid_reg;
    assign bus.rsp_set   = s1_set_reg;
    assign bus.rsp_way   = (s1_op_reg == LRU_OP_FILL) ? s1_victim : s1_way_reg;
    assign init_done     = (state_reg == ST_READY);

    always_comb begin
        state_next    = state_reg;
        init_ptr_next = init_ptr_reg;
        init_wr       = 1'b0;
        case (state_reg)
            ST_INIT: begin
                init_wr       = 1'b1;
                init_ptr_next = init_ptr_reg + 1'b1;
                if (init_ptr_reg == SET_W'(NUM_SETS - 1)) begin
                    state_next = ST_READY;
                end
            end
            ST_READY: begin
                if (flush) begin
                    init_ptr_next = '0;
                    state_next    = (!s1_valid_reg || rsp_fire) ? ST_INIT : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (rsp_fire) begin
                    init_ptr_next = '0;
                    state_next    = ST_INIT;
                end
            end
            default: begin
                init_ptr_next = '0;
                state_next    = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_INIT;
            init_ptr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            init_ptr_reg <= init_ptr_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_op_reg    <= LRU_OP_TOUCH;
            s1_set_reg   <= '0;
            s1_way_reg   <= '0;
            s1_order_reg <= '0;
        end else if (accept) begin
            s1_valid_reg <= 1'b1;
            s1_op_reg    <= bus.req_op;
            s1_set_reg   <= bus.req_set;
            s1_way_reg   <= bus.req_way;
            s1_order_reg <= s0_order;
        end else if (rsp_fire) begin
            s1_valid_reg <= 1'b0;
        end
    end

    for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_set
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                order_reg[gi] <= IDENT;
            end else if (init_wr && (init_ptr_reg == SET_W'(gi))) begin
                order_reg[gi] <= IDENT;
            end else if (rsp_fire && (s1_set_reg == SET_W'(gi))) begin
                order_reg[gi] <= s1_new_order;
            end
        end

        a_perm: assert property (@(posedge clk) disable iff (reset) is_perm(order_reg[gi]));
    end

    a_no_rsvd_op: assert property (@(posedge clk) disable iff (reset)
                                   !(accept && (bus.req_op == 2'd3)));

endmodule

// File: tb/tb_vx_lru_way_sched.sv
// Directed-vector bench for vx_lru_way_sched: init sweep timing, FILL/TOUCH/INVAL ordering,
// same-set bypass, response stall, flush via DRAIN and asynchronous reset restart.
module tb_vx_lru_way_sched;
    import vx_lru_pkg::*;

    localparam int NUM_SETS = 16;
    localparam int NUM_WAYS = 4;
    localparam int SET_W    = 4;
    localparam int WAY_W    = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic init_done;

    vx_lru_way_sched_if #(.SET_W(SET_W), .WAY_W(WAY_W)) bus ();

    vx_lru_way_sched #(
        .NUM_SETS (NUM_SETS),
        .NUM_WAYS (NUM_WAYS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .init_done (init_done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int prev_set = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    // One pipelined slot: check the response of the previous accepted request, then present the next.
    task automatic step(input bit v, input logic [1:0] op, input int set, input int way,
                        input bit chk_rsp, input int exp_way);
        @(negedge clk);
        if (chk_rsp) begin
            chk("rsp_valid", int'(bus.rsp_valid), 1);
            chk("rsp_way", int'(bus.rsp_way), exp_way);
            chk("rsp_set", int'(bus.rsp_set), prev_set);
            $display("txn rsp set=%0d way=%0d (want %0d)", bus.rsp_set, bus.rsp_way, exp_way);
        end
        bus.req_valid = v;
        bus.req_op    = op;
        bus.req_set   = set[SET_W-1:0];
        bus.req_way   = way[WAY_W-1:0];
        bus.rsp_ready = 1'b1;
        #1;
        if (v) begin
            chk("req_ready", int'(bus.req_ready), 1);
            $display("txn req op=%0d set=%0d way=%0d", op, set, way);
            prev_set = set;
        end
        @(posedge clk);
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (!init_done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 8) chk("ready_during_init", int'(bus.req_ready), 0);
        end
        chk(tag, n, NUM_SETS);
        $display("txn init sweep took %0d cycles", n);
    endtask

    // Requester-side protocol: a request refused must be held unchanged next cycle.
    logic       hold_q = 1'b0;
    logic [8:0] hold_snap = '0;
    always begin
        @(negedge clk);
        #3;
        if (reset) begin
            hold_q = 1'b0;
        end else begin
            if (hold_q) chk("proto_hold",
                            int'({bus.req_valid, bus.req_op, bus.req_set, bus.req_way}),
                            int'(hold_snap));
            hold_q    = bus.req_valid && !bus.req_ready;
            hold_snap = {bus.req_valid, bus.req_op, bus.req_set, bus.req_way};
        end
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = LRU_OP_TOUCH;
        bus.req_set   = '0;
        bus.req_way   = '0;
        bus.rsp_ready = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", int'(bus.req_ready), 0);
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_init_done", int'(init_done), 0);
        chk("rst_rsp_set", int'(bus.rsp_set), 0);
        chk("rst_rsp_way", int'(bus.rsp_way), 0);
        @(negedge clk);
        reset = 1'b0;
        wait_init("init_after_reset");

        // Set 3: five back-to-back FILLs walk the identity order.
        step(1, LRU_OP_FILL, 3, 0, 0, 0);
        step(1, LRU_OP_FILL, 3, 0, 1, 0);
        step(1, LRU_OP_FILL, 3, 0, 1, 1);
        step(1, LRU_OP_FILL, 3, 0, 1, 2);
        step(1, LRU_OP_FILL, 3, 0, 1, 3);
        step(0, LRU_OP_TOUCH, 0, 0, 1, 0);

        // Set 5: TOUCH 0 -> [1,2,3,0]; FILL v1 -> [2,3,0,1]; INVAL 3 -> [3,2,0,1]; FILL v3.
        step(1, LRU_OP_TOUCH, 5, 0, 0, 0);
        step(1, LRU_OP_FILL,  5, 0, 1, 0);
        step(1, LRU_OP_INVAL, 5, 3, 1, 1);
        step(1, LRU_OP_FILL,  5, 0, 1, 3);
        step(0, LRU_OP_TOUCH, 0, 0, 1, 3);

        // Set 7: TOUCH 2 -> [0,1,3,2]; FILL v0 -> [1,3,2,0]; TOUCH 0 (MRU) ; FILL v1.
        step(1, LRU_OP_TOUCH, 7, 2, 0, 0);
        step(1, LRU_OP_FILL,  7, 0, 1, 2);
        step(1, LRU_OP_TOUCH, 7, 0, 1, 0);
        step(1, LRU_OP_FILL,  7, 0, 1, 0);
        step(0, LRU_OP_TOUCH, 0, 0, 1, 1);

        // Set 1: response stalled three cycles with a second FILL waiting.
        step(1, LRU_OP_FILL, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.rsp_ready = 1'b0;
            #1;
            chk("stall_rsp_valid", int'(bus.rsp_valid), 1);
            chk("stall_rsp_way", int'(bus.rsp_way), 0);
            chk("stall_req_ready", int'(bus.req_ready), 0);
            @(posedge clk);
        end
        step(1, LRU_OP_FILL, 1, 0, 1, 0);
        step(0, LRU_OP_TOUCH, 0, 0, 1, 1);

        // Flush while S1 is stalled goes through DRAIN before the sweep.
        step(1, LRU_OP_FILL, 4, 0, 0, 0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        flush = 1'b1;
        #1;
        chk("flush_req_ready", int'(bus.req_ready), 0);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("drain_init_done", int'(init_done), 0);
        chk("drain_rsp_valid", int'(bus.rsp_valid), 1);
        chk("drain_rsp_way", int'(bus.rsp_way), 0);
        @(posedge clk);
        @(negedge clk);
        chk("drain_hold_valid", int'(bus.rsp_valid), 1);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("drain_done_valid", int'(bus.rsp_valid), 0);
        wait_init("init_after_drain");

        step(1, LRU_OP_FILL, 4, 0, 0, 0);
        step(1, LRU_OP_FILL, 3, 0, 1, 0);
        step(0, LRU_OP_TOUCH, 0, 0, 1, 0);

        // Flush with S1 empty, then an asynchronous reset partway through the sweep.
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush2_req_ready", int'(bus.req_ready), 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush2_init_done", int'(init_done), 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_req_ready", int'(bus.req_ready), 0);
        chk("mid_rst_init_done", int'(init_done), 0);
        @(negedge clk);
        reset = 1'b0;
        wait_init("init_after_mid_reset");

        // Asynchronous reset with a response pending drops it.
        step(1, LRU_OP_FILL, 2, 0, 0, 0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_drop_rsp_valid", int'(bus.rsp_valid), 0);
        @(negedge clk);
        reset = 1'b0;
        wait_init("init_after_drop");
        step(1, LRU_OP_FILL, 2, 0, 0, 0);
        step(0, LRU_OP_TOUCH, 0, 0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
